alu_pipe: RTL

- Parametrised, pipelined successor to the generated combinational ALUs.
- Width is generic. Shift ops are extended with SLL/SRL. Flags are registered alongside the result.
- Operations enter and leave through valid/ready handshakes with full backpressure.
- Sits between the operand-fetch stage and the writeback/flag-register stage of the datapath.

---
 rtl/alu_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the operand bundle; stage 2 computes and registers the
// result together with carry, zero, overflow and sign flags.
// Optional feature: define ALU_STICKY_OVF_EN to add clearSticky/stickyOvf,
// a sticky overflow bit set by any delivered bundle that overflowed.
module alu_pipe #(
  parameter int WIDTH = 64,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHIFT_W-1:0] shiftValue,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef ALU_STICKY_OVF_EN
  input  logic               clearSticky,
  output logic               stickyOvf,
`endif
  output logic [WIDTH-1:0]   result,
  output logic               carryFlag,
  output logic               zeroFlag,
  output logic               overFlowFlag,
  output logic               signFlag
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SRA = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  logic               s1_valid;
  logic [3:0]         s1_opcode;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [SHIFT_W-1:0] s1_shamt;
  logic               s2_valid;
  logic               adv2;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  // Stage 2 can take a new bundle when empty or when its current one leaves;
  // stage 1 can take one when empty or when it can move into stage 2.
  assign adv2      = !s2_valid | out_ready;
  assign in_ready  = !s1_valid | adv2;
  assign out_valid = s2_valid;

  // Compute the result and carry/overflow from the stage-1 bundle.
  always_comb begin
    sum       = {1'b0, s1_a} + {1'b0, s1_b};
    diff      = {1'b0, s1_a} - {1'b0, s1_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (s1_opcode)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &
                    (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &
                    (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_NOR:  alu_res = ~(s1_a | s1_b);
      OP_SRA:  alu_res = $signed(s1_a) >>> s1_shamt;
      OP_SLL:  alu_res = s1_a << s1_shamt;
      OP_SRL:  alu_res = s1_a >> s1_shamt;
      default: alu_res = '0;
    endcase
  end

  // Stage 1: capture the incoming bundle whenever the stage can accept one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_shamt  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_opcode <= opcode;
        s1_a      <= input1;
        s1_b      <= input2;
        s1_shamt  <= shiftValue;
      end
    end
  end

  // Stage 2: register result and flags; hold them while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid     <= 1'b0;
      result       <= '0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      overFlowFlag <= 1'b0;
      signFlag     <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result       <= alu_res;
        carryFlag    <= alu_carry;
        zeroFlag     <= (alu_res == '0);
        overFlowFlag <= alu_ovf;
        signFlag     <= alu_res[WIDTH-1];
      end
    end
  end

`ifdef ALU_STICKY_OVF_EN
  // Sticky overflow: set by a delivered overflowing bundle, set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stickyOvf <= 1'b0;
    end else if (s2_valid & out_ready & overFlowFlag) begin
      stickyOvf <= 1'b1;
    end else if (clearSticky) begin
      stickyOvf <= 1'b0;
    end
  end
`endif

endmodule
